// File: rtl/cgra_cfg_loader_pkg.sv
// Shared types and constants for the CGRA configuration loader.
package cgra_cfg_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DRAIN,
    DONE,
    ERR
  } cfg_state_t;

  localparam int BYTES_PER_WORD     = 4;
  localparam int DEFAULT_FIFO_DEPTH = 4;

endpackage

// File: rtl/cgra_cfg_loader_if.sv
// Memory read port and PE-array configuration write bus of the loader.
interface cgra_cfg_loader_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int IDX_WIDTH  = 16
);
  import cgra_cfg_pkg::*;

  logic                  mem_req_valid;
  logic                  mem_req_ready;
  logic [ADDR_WIDTH-1:0] mem_req_addr;
  logic                  mem_rsp_valid;
  logic [DATA_WIDTH-1:0] mem_rsp_data;
  logic                  mem_rsp_err;
  logic                  cfg_wr_valid;
  logic                  cfg_wr_ready;
  logic [IDX_WIDTH-1:0]  cfg_wr_idx;
  logic [DATA_WIDTH-1:0] cfg_wr_data;

  modport master (
    output mem_req_valid, mem_req_addr,
    input  mem_req_ready,
    input  mem_rsp_valid, mem_rsp_data, mem_rsp_err,
    output cfg_wr_valid, cfg_wr_idx, cfg_wr_data,
    input  cfg_wr_ready
  );

  modport slave (
    input  mem_req_valid, mem_req_addr,
    output mem_req_ready,
    output mem_rsp_valid, mem_rsp_data, mem_rsp_err,
    input  cfg_wr_valid, cfg_wr_idx, cfg_wr_data,
    output cfg_wr_ready
  );

endinterface

// File: rtl/cgra_cfg_loader_fifo.sv
// Synchronous FIFO buffering memory responses ahead of the config bus.
module cgra_cfg_fifo #(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] pop_data_o,
  output logic [CW-1:0]    count_o,
  output logic             empty_o,
  output logic             full_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push;
  logic             do_pop;

  assign empty_o    = (count_q == '0);
  assign full_o     = (count_q == CW'(DEPTH));
  assign do_push    = push_i && !full_o;
  assign do_pop     = pop_i && !empty_o;
  assign pop_data_o = mem_q[rd_ptr_q];
  assign count_o    = count_q;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/cgra_cfg_loader.sv
// Fetches a configuration bitstream from memory and streams it onto the PE-array config bus.
// Optional macro CGRA_CFG_CHECKSUM_EN: final word is an XOR-fold checksum, checked instead of forwarded.
module cgra_cfg_loader
  import cgra_cfg_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH,
  parameter int IDX_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cfg_start,
  input  logic                  cgra_reset,
  input  logic [ADDR_WIDTH-1:0] bitstream_addr,
  input  logic [15:0]           bitstream_size,
  cgra_cfg_loader_if.master     bus,
  output logic                  cfg_busy,
  output logic                  cfg_done,
  output logic                  cfg_error
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(FIFO_DEPTH);

  cfg_state_t            state_q, state_d;
  logic                  start_q;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [15:0]           size_q, size_d;
  logic [15:0]           req_cnt_q, req_cnt_d;
  logic [15:0]           wr_cnt_q, wr_cnt_d;
  logic [CW-1:0]         outst_q, outst_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;

  logic                  fifo_push, fifo_pop, fifo_flush;
  logic [DATA_WIDTH-1:0] fifo_head;
  logic [CW-1:0]         fifo_count;
  logic                  fifo_empty, fifo_full;

  logic                  active, start_ok, req_valid, req_fire;
  logic                  rsp_bad, wr_valid, wr_fire;
  logic [15:0]           fwd_total;
  logic [CW:0]           credit_sum;

  assign active     = (state_q == FETCH) || (state_q == DRAIN);
  assign start_ok   = cfg_start && !start_q && !cgra_reset && (outst_q == '0) &&
                      ((state_q == IDLE) || (state_q == DONE) || (state_q == ERR));
  assign credit_sum = {1'b0, outst_q} + {1'b0, fifo_count};
  assign req_valid  = (state_q == FETCH) && (req_cnt_q < size_q) && (credit_sum < DEPTH_C);
  assign req_fire   = req_valid && bus.mem_req_ready;
  assign rsp_bad    = bus.mem_rsp_valid && bus.mem_rsp_err && active;
  assign wr_valid   = active && !fifo_empty && (wr_cnt_q < fwd_total);
  assign wr_fire    = wr_valid && bus.cfg_wr_ready;

`ifdef CGRA_CFG_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] xor_q, xor_d;
  logic                  chk_pop;

  assign fwd_total = size_q - 16'd1;
  assign chk_pop   = active && !fifo_empty && (wr_cnt_q == fwd_total);
  assign fifo_pop  = wr_fire || chk_pop;
`else
  assign fwd_total = size_q;
  assign fifo_pop  = wr_fire;
`endif

  // Responses landing after an abort or error are still counted but never buffered.
  assign fifo_push  = bus.mem_rsp_valid && !bus.mem_rsp_err && active && !cgra_reset && !fifo_full;
  assign fifo_flush = rsp_bad || cgra_reset;

  cgra_cfg_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush_i     (fifo_flush),
    .push_i      (fifo_push),
    .push_data_i (bus.mem_rsp_data),
    .pop_i       (fifo_pop),
    .pop_data_o  (fifo_head),
    .count_o     (fifo_count),
    .empty_o     (fifo_empty),
    .full_o      (fifo_full)
  );

  assign bus.mem_req_valid = req_valid;
  assign bus.mem_req_addr  = base_q + (ADDR_WIDTH'(req_cnt_q) * ADDR_WIDTH'(BYTES_PER_WORD));
  assign bus.cfg_wr_valid  = wr_valid;
  assign bus.cfg_wr_idx    = IDX_WIDTH'(wr_cnt_q);
  assign bus.cfg_wr_data   = wr_valid ? fifo_head : '0;
  assign cfg_busy          = active;
  assign cfg_done          = done_q;
  assign cfg_error         = error_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      start_q   <= 1'b0;
      base_q    <= '0;
      size_q    <= '0;
      req_cnt_q <= '0;
      wr_cnt_q  <= '0;
      outst_q   <= '0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
`ifdef CGRA_CFG_CHECKSUM_EN
      xor_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      start_q   <= cfg_start;
      base_q    <= base_d;
      size_q    <= size_d;
      req_cnt_q <= req_cnt_d;
      wr_cnt_q  <= wr_cnt_d;
      outst_q   <= outst_d;
      done_q    <= done_d;
      error_q   <= error_d;
`ifdef CGRA_CFG_CHECKSUM_EN
      xor_q     <= xor_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    size_d    = size_q;
    req_cnt_d = req_cnt_q;
    wr_cnt_d  = wr_cnt_q;
    outst_d   = outst_q;
    done_d    = done_q;
    error_d   = error_q;
`ifdef CGRA_CFG_CHECKSUM_EN
    xor_d     = xor_q;
`endif

    // Outstanding reads are tracked in every state so aborts cannot orphan responses.
    case ({req_fire, bus.mem_rsp_valid})
      2'b10:   outst_d = outst_q + CW'(1);
      2'b01:   if (outst_q != '0) outst_d = outst_q - CW'(1);
      default: ;
    endcase

    if (cgra_reset) begin
      state_d = IDLE;
      done_d  = 1'b0;
      error_d = 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE, ERR: begin
          if (start_ok) begin
            base_d    = bitstream_addr;
            size_d    = bitstream_size;
            req_cnt_d = '0;
            wr_cnt_d  = '0;
            error_d   = 1'b0;
`ifdef CGRA_CFG_CHECKSUM_EN
            xor_d     = '0;
`endif
            if (bitstream_size == 16'd0) begin
              state_d = DONE;
              done_d  = 1'b1;
            end else begin
              state_d = FETCH;
              done_d  = 1'b0;
            end
          end
        end
        FETCH, DRAIN: begin
          if (rsp_bad) begin
            state_d = ERR;
            error_d = 1'b1;
          end else begin
            if (req_fire) req_cnt_d = req_cnt_q + 16'd1;
            if ((state_q == FETCH) && (req_cnt_d == size_q)) state_d = DRAIN;
            if (wr_fire) begin
              wr_cnt_d = wr_cnt_q + 16'd1;
`ifdef CGRA_CFG_CHECKSUM_EN
              xor_d    = xor_q ^ fifo_head;
`endif
            end
`ifdef CGRA_CFG_CHECKSUM_EN
            if (chk_pop) begin
              if (fifo_head == xor_q) begin
                state_d = DONE;
                done_d  = 1'b1;
              end else begin
                state_d = ERR;
                error_d = 1'b1;
              end
            end
`else
            if (wr_fire && (wr_cnt_d == size_q)) begin
              state_d = DONE;
              done_d  = 1'b1;
            end
`endif
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

endmodule
